// File: rtl/valid_ready_accum_pkg.sv
// rtl/valid_ready_accum_pkg.sv - shared types and helpers for the valid/ready accumulator
package valid_ready_accum_pkg;

  typedef enum logic {
    ACC_UNSIGNED = 1'b0,
    ACC_SIGNED   = 1'b1
  } acc_sign_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/valid_ready_accum_if.sv
// rtl/valid_ready_accum_if.sv - input beat / result beat handshake bundle
interface valid_ready_accum_if
  import valid_ready_accum_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int ACC_N  = 4
);
  localparam int CNT_W = clog2(ACC_N + 1);
  localparam int OUT_W = DATA_W + clog2(ACC_N);

  logic [DATA_W-1:0] data_in;
  logic              valid_a;
  logic              last_a;
  logic              ready_a;
  logic              valid_b;
  logic              ready_b;
  logic [OUT_W-1:0]  data_out;
  logic [CNT_W-1:0]  beats_b;

  modport master (
    output data_in, valid_a, last_a, ready_b,
    input  ready_a, valid_b, data_out, beats_b
  );

  modport slave (
    input  data_in, valid_a, last_a, ready_b,
    output ready_a, valid_b, data_out, beats_b
  );
endinterface

// File: rtl/valid_ready_accum_out_slot.sv
// rtl/valid_ready_accum_out_slot.sv - one-entry result register with valid/ready
module valid_ready_out_slot #(
  parameter int OUT_W = 10,
  parameter int CNT_W = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [OUT_W-1:0] load_data,
  input  logic [CNT_W-1:0] load_beats,
  input  logic             ready_b,
  output logic             out_free,
  output logic             valid_b,
  output logic [OUT_W-1:0] data_out,
  output logic [CNT_W-1:0] beats_b
);

  assign out_free = ~valid_b | ready_b;

  // A load while the old result drains keeps valid_b high: back-to-back results.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      valid_b  <= 1'b0;
      data_out <= '0;
      beats_b  <= '0;
    end else if (load) begin
      valid_b  <= 1'b1;
      data_out <= load_data;
      beats_b  <= load_beats;
    end else if (valid_b && ready_b) begin
      valid_b <= 1'b0;
    end
  end

endmodule

// File: rtl/valid_ready_accum.sv
// rtl/valid_ready_accum.sv - sums groups of ACC_N beats (or shorter, closed by last_a)
module valid_ready_accum
  import valid_ready_accum_pkg::*;
#(
  parameter int        DATA_W = 8,
  parameter int        ACC_N  = 4,
  parameter acc_sign_e SIGNED = ACC_UNSIGNED
) (
  input logic clk,
  input logic rst,
  valid_ready_accum_if.slave bus
);
  localparam int CNT_W = clog2(ACC_N + 1);
  localparam int OUT_W = DATA_W + clog2(ACC_N);

  logic [CNT_W-1:0] cnt;
  logic [OUT_W-1:0] acc;
  logic [OUT_W-1:0] ext_in;
  logic [OUT_W-1:0] acc_sum;
  logic             out_free;
  logic             last_beat;
  logic             acc_fire;
  logic             close;

  function automatic logic [OUT_W-1:0] ext(input logic [DATA_W-1:0] d);
    logic fill;
    fill = (SIGNED == ACC_SIGNED) ? d[DATA_W-1] : 1'b0;
    return {{(OUT_W-DATA_W){fill}}, d};
  endfunction

  assign ext_in    = ext(bus.data_in);
  assign acc_sum   = ((cnt == '0) ? '0 : acc) + ext_in;
  assign last_beat = (cnt == CNT_W'(ACC_N - 1));

  // Non-closing beats never touch the output slot, so they flow even while it is stalled.
  assign bus.ready_a = out_free | (~bus.last_a & ~last_beat);
  assign acc_fire    = bus.valid_a & bus.ready_a;
  assign close       = acc_fire & (bus.last_a | last_beat);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc <= '0;
      cnt <= '0;
    end else if (acc_fire) begin
      if (close) begin
        cnt <= '0;
      end else begin
        acc <= acc_sum;
        cnt <= cnt + CNT_W'(1);
      end
    end
  end

  valid_ready_out_slot #(
    .OUT_W (OUT_W),
    .CNT_W (CNT_W)
  ) u_out_slot (
    .clk        (clk),
    .rst        (rst),
    .load       (close),
    .load_data  (acc_sum),
    .load_beats (cnt + CNT_W'(1)),
    .ready_b    (bus.ready_b),
    .out_free   (out_free),
    .valid_b    (bus.valid_b),
    .data_out   (bus.data_out),
    .beats_b    (bus.beats_b)
  );

endmodule

// File: tb/tb_valid_ready_accum.sv
// tb/tb_valid_ready_accum.sv - directed and model-checked bench for valid_ready_accum
module tb_valid_ready_accum;
  import valid_ready_accum_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  valid_ready_accum_if #(.DATA_W(8),  .ACC_N(4)) da ();
  valid_ready_accum_if #(.DATA_W(8),  .ACC_N(4)) sg ();
  valid_ready_accum_if #(.DATA_W(12), .ACC_N(5)) f5 ();

  valid_ready_accum #(.DATA_W(8), .ACC_N(4), .SIGNED(ACC_UNSIGNED)) u_da (.clk(clk), .rst(rst), .bus(da));
  valid_ready_accum #(.DATA_W(8), .ACC_N(4), .SIGNED(ACC_SIGNED))   u_sg (.clk(clk), .rst(rst), .bus(sg));
  valid_ready_accum #(.DATA_W(12), .ACC_N(5), .SIGNED(ACC_UNSIGNED)) u_f5 (.clk(clk), .rst(rst), .bus(f5));

  typedef struct {
    logic       v;
    logic       l;
    logic [7:0] d;
    logic       rb;
    logic       ra;
    logic       vb;
    logic [9:0] dout;
    logic [2:0] bt;
  } vec_t;

  typedef struct {
    int sum;
    int beats;
  } res_t;

  vec_t tbl[$];
  res_t exp_q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t", name, act, act, exp, exp, $time);
    end
  endtask

  task automatic add(input logic v, l, input logic [7:0] d, input logic rb,
                     input logic ra, vb, input logic [9:0] dout, input logic [2:0] bt);
    vec_t r;
    r.v = v; r.l = l; r.d = d; r.rb = rb; r.ra = ra; r.vb = vb; r.dout = dout; r.bt = bt;
    tbl.push_back(r);
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic beat_da(input logic v, l, input logic [7:0] d, input logic rb);
    da.valid_a = v; da.last_a = l; da.data_in = d; da.ready_b = rb;
    step();
  endtask

  initial begin
    int   m_sum;
    int   m_cnt;
    logic exp_ra;
    res_t r;

    {da.valid_a, da.last_a, da.data_in, da.ready_b} = '0;
    {sg.valid_a, sg.last_a, sg.data_in, sg.ready_b} = '0;
    {f5.valid_a, f5.last_a, f5.data_in, f5.ready_b} = '0;

    #3;
    chk("reset valid_b", 32'(da.valid_b), 32'd0);
    chk("reset data_out", 32'(da.data_out), 32'd0);
    chk("reset beats_b", 32'(da.beats_b), 32'd0);
    chk("reset ready_a", 32'(da.ready_a), 32'd1);
    @(negedge clk);
    rst = 1'b0;

    //   v  l  d    rb  ra vb dout bt
    add(1, 0, 1,   1,  1, 0, 0,   0);
    add(1, 0, 2,   1,  1, 0, 0,   0);
    add(1, 0, 3,   1,  1, 0, 0,   0);
    add(1, 0, 4,   1,  1, 0, 0,   0);
    add(1, 0, 5,   1,  1, 1, 10,  4);
    add(1, 0, 6,   1,  1, 0, 10,  4);
    add(1, 0, 7,   1,  1, 0, 10,  4);
    add(1, 0, 8,   1,  1, 0, 10,  4);
    add(0, 0, 0,   1,  1, 1, 26,  4);
    add(0, 0, 0,   1,  1, 0, 26,  4);
    add(1, 0, 1,   0,  1, 0, 26,  4);
    add(1, 0, 2,   0,  1, 0, 26,  4);
    add(1, 0, 3,   0,  1, 0, 26,  4);
    add(1, 0, 4,   0,  1, 0, 26,  4);
    add(1, 0, 5,   0,  1, 1, 10,  4);
    add(1, 0, 6,   0,  1, 1, 10,  4);
    add(1, 0, 7,   0,  1, 1, 10,  4);
    add(1, 0, 8,   0,  0, 1, 10,  4);
    add(1, 0, 8,   0,  0, 1, 10,  4);
    add(1, 0, 8,   1,  1, 1, 10,  4);
    add(0, 0, 0,   0,  1, 1, 26,  4);
    add(0, 0, 0,   1,  1, 1, 26,  4);
    add(1, 0, 9,   1,  1, 0, 26,  4);
    add(1, 1, 9,   1,  1, 0, 26,  4);
    add(1, 1, 200, 1,  1, 1, 18,  2);
    add(0, 0, 0,   1,  1, 1, 200, 1);
    add(0, 0, 0,   1,  1, 0, 200, 1);
    add(1, 1, 3,   1,  1, 0, 200, 1);
    add(0, 1, 0,   0,  0, 1, 3,   1);
    add(0, 0, 0,   0,  1, 1, 3,   1);
    add(0, 0, 0,   1,  1, 1, 3,   1);
    add(0, 0, 0,   1,  1, 0, 3,   1);

    foreach (tbl[i]) begin
      da.valid_a = tbl[i].v; da.last_a = tbl[i].l; da.data_in = tbl[i].d; da.ready_b = tbl[i].rb;
      #1;
      chk($sformatf("vec%0d ready_a", i), 32'(da.ready_a), 32'(tbl[i].ra));
      chk($sformatf("vec%0d valid_b", i), 32'(da.valid_b), 32'(tbl[i].vb));
      chk($sformatf("vec%0d data_out", i), 32'(da.data_out), 32'(tbl[i].dout));
      chk($sformatf("vec%0d beats_b", i), 32'(da.beats_b), 32'(tbl[i].bt));
      @(posedge clk);
      @(negedge clk);
    end

    for (int i = 0; i < 4; i++) beat_da(1, 0, 8'd255, 1);
    da.valid_a = 0;
    chk("unsigned 255x4 valid_b", 32'(da.valid_b), 32'd1);
    chk("unsigned 255x4 sum", 32'(da.data_out), 32'd1020);
    chk("unsigned 255x4 beats", 32'(da.beats_b), 32'd4);

    for (int i = 0; i < 4; i++) begin
      sg.valid_a = 1; sg.last_a = 0; sg.data_in = 8'h80; sg.ready_b = 1;
      step();
    end
    sg.valid_a = 0;
    chk("signed -128x4 valid_b", 32'(sg.valid_b), 32'd1);
    chk("signed -128x4 sum", 32'(sg.data_out), 32'h200);
    chk("signed -128x4 beats", 32'(sg.beats_b), 32'd4);

    for (int i = 0; i < 5; i++) begin
      f5.valid_a = 1; f5.last_a = 0; f5.data_in = 12'hFFF; f5.ready_b = 1;
      step();
    end
    f5.valid_a = 0;
    chk("acc5 4095x5 valid_b", 32'(f5.valid_b), 32'd1);
    chk("acc5 4095x5 sum", 32'(f5.data_out), 32'd20475);
    chk("acc5 4095x5 beats", 32'(f5.beats_b), 32'd5);
    step();

    // Random traffic on the ACC_N=5 instance against a small reference model.
    m_sum = 0;
    m_cnt = 0;
    exp_q.delete();
    for (int c = 0; c < 400; c++) begin
      if (c < 380) begin
        f5.valid_a = 1'($urandom_range(0, 1));
        f5.last_a  = ($urandom_range(0, 3) == 0);
        f5.data_in = 12'($urandom_range(0, 4095));
        f5.ready_b = 1'($urandom_range(0, 1));
      end else begin
        f5.valid_a = 0; f5.last_a = 0; f5.ready_b = 1;
      end
      #1;
      exp_ra = (exp_q.size() == 0) || f5.ready_b || (!f5.last_a && m_cnt != 4);
      if (f5.ready_a !== exp_ra || f5.valid_b !== (exp_q.size() != 0)) begin
        chk($sformatf("rand c%0d ready_a", c), 32'(f5.ready_a), 32'(exp_ra));
        chk($sformatf("rand c%0d valid_b", c), 32'(f5.valid_b), 32'(exp_q.size() != 0));
      end
      if (exp_q.size() != 0 && f5.ready_b) begin
        r = exp_q.pop_front();
        chk($sformatf("rand c%0d sum", c), 32'(f5.data_out), 32'(r.sum));
        chk($sformatf("rand c%0d beats", c), 32'(f5.beats_b), 32'(r.beats));
      end
      if (f5.valid_a && exp_ra) begin
        m_sum += int'(f5.data_in);
        m_cnt++;
        if (f5.last_a || m_cnt == 5) begin
          r.sum = m_sum & 32'h7FFF;
          r.beats = m_cnt;
          exp_q.push_back(r);
          m_sum = 0;
          m_cnt = 0;
        end
      end
      step();
    end
    chk("rand drained", 32'(exp_q.size()), 32'd0);

    // Reset in the middle of a partial group with a result pending.
    for (int i = 1; i <= 4; i++) beat_da(1, 0, 8'(i), 0);
    beat_da(1, 0, 8'd1, 0);
    beat_da(1, 0, 8'd1, 0);
    da.valid_a = 0;
    chk("pre-reset valid_b", 32'(da.valid_b), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("mid reset valid_b", 32'(da.valid_b), 32'd0);
    chk("mid reset data_out", 32'(da.data_out), 32'd0);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 4; i++) beat_da(1, 0, 8'd1, 1);
    da.valid_a = 0;
    chk("post-reset valid_b", 32'(da.valid_b), 32'd1);
    chk("post-reset sum", 32'(da.data_out), 32'd4);
    chk("post-reset beats", 32'(da.beats_b), 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
